freq_cmd_sequencer: RTL and testbench
=====================================

# freq_cmd_sequencer

Controller that sequences the microphone frequency-decoding path each time the rover finds a washer. It enables the hearing datapath, lets it settle, and waits for a stable, valid command code. It then issues one movement request to the drive logic over a valid/ready handshake, waits for completion, and re-arms. It sits between the washer detector, the frequency-to-command decoder (3-bit one-hot command, 0 = none), and the rover motion controller.

## Interface
- SETTLE_CYCLES, 1000: cycles after enabling the mic before decoded commands are trusted.
- STABLE_CYCLES, 5000: consecutive cycles an identical valid command must persist before it is accepted.
- LISTEN_TIMEOUT, 100_000_000: maximum cycles spent listening before giving up.
- TRACK_HOLD, 50_000_000: cycles the mic stays enabled in sound-tracking mode after a go-to-sound command.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- washer_found  in  1  level; rising edge starts a sequence.
- hear_cmd  in  3  decoded command: 001 turn 180, 010 store washer, 100 go to sound, anything else none.
- move_ready  in  1  motion controller accepts a request.
- move_done  in  1  one-cycle pulse when the accepted move completes.
- hear_en  out  1  enable to the frequency-decoding datapath.
- move_valid  out  1  movement request valid.
- move_cmd  out  3  accepted one-hot command; stable while move_valid is high.
- find_sound  out  1  high while in sound-tracking mode.
- busy  out  1  high in every state except IDLE.
- timeout  out  1  one-cycle pulse when listening times out.

## Operation
- States: IDLE, SETTLE, LISTEN, ISSUE, WAIT_DONE, TRACK.
- IDLE → SETTLE: on a rising edge of washer_found, detected against a registered copy. A level held high does not retrigger.
- SETTLE: hear_en=1; counts SETTLE_CYCLES, then goes to LISTEN. Candidate and stability counters are cleared on entry.
- LISTEN: hear_en=1; listen counter increments every cycle.
  - Valid codes are exactly 001, 010 and 100.
  - Valid hear_cmd equal to the candidate: stability count increments, saturating at STABLE_CYCLES.
  - Valid hear_cmd different from the candidate: the new code is loaded as candidate with count 1.
  - Invalid or zero hear_cmd: count clears to 0.
  - Count reaching STABLE_CYCLES: move_cmd latches the candidate, then go to ISSUE.
  - Listen counter reaching LISTEN_TIMEOUT with no acceptance: pulse timeout, go to IDLE.
  - If acceptance and timeout fall on the same cycle, acceptance wins.
- ISSUE: hear_en=0, except for 100 where it stays 1; move_valid=1. When move_valid && move_ready, go to WAIT_DONE for 001/010 and to TRACK for 100.
- WAIT_DONE: move_valid=0; on move_done, go to IDLE.
- TRACK: hear_en=1, find_sound=1; counts TRACK_HOLD cycles, or exits early on move_done, then goes to IDLE.
- washer_found edges are ignored while busy.
- Counters are sized with $clog2 of their parameter plus 1 and never wrap.

## Timing
- Reset values: hear_en=0, move_valid=0, move_cmd=000, find_sound=0, busy=0, timeout=0, state IDLE, all counters 0.
- All outputs are registered.
- hear_en rises 1 cycle after the washer_found edge.
- Earliest move_valid is SETTLE_CYCLES + STABLE_CYCLES + 1 cycles after the edge.
- move_cmd and move_valid stay constant until the handshake completes; move_valid drops the cycle after acceptance.
- rst asserted in any state returns everything to reset values on the next edge. An in-flight move request is dropped.
- move_done seen outside WAIT_DONE/TRACK is ignored.

## Configuration
- FREQ_SEQ_RETRY_EN defined: on the first listen timeout of a sequence, return to SETTLE once with a retry flag set. The timeout pulse and return to IDLE happen only on the second timeout. The retry flag clears in IDLE.
- FREQ_SEQ_RETRY_EN undefined: the first timeout pulses timeout and returns to IDLE.

## Test plan
- Test parameters: SETTLE=4, STABLE=3, TIMEOUT=20, TRACK=10.
- washer_found edge, then hear_cmd=010 held → move_valid high on cycle 8 with move_cmd=010; move_ready=1 → WAIT_DONE; move_done → IDLE with busy=0.
- hear_cmd sequence 001,001,100,100,100 in LISTEN → accepted command 100, hear_en remains 1 through ISSUE, find_sound=1 for 10 cycles, then IDLE.
- hear_cmd=011 (invalid) or 000 for the whole listen → timeout pulse exactly 20 cycles after entering LISTEN. With FREQ_SEQ_RETRY_EN, a second SETTLE+LISTEN precedes the pulse.
- move_ready held low for 7 cycles in ISSUE → move_valid and move_cmd constant throughout; transition on the first ready cycle.
- rst asserted mid-LISTEN and mid-ISSUE → all outputs at reset values the next cycle. washer_found held high across reset does not restart until it falls and rises again.

Source files
------------

// File: rtl/freq_cmd_sequencer_if.sv
// Handshake bundle between the washer/decoder/motion side and freq_cmd_sequencer.
// The master modport is the sequencer's view; slave is the environment's view.
interface freq_cmd_sequencer_if;
    logic       washer_found;
    logic [2:0] hear_cmd;
    logic       move_ready;
    logic       move_done;
    logic       hear_en;
    logic       move_valid;
    logic [2:0] move_cmd;
    logic       find_sound;
    logic       busy;
    logic       timeout;

    modport master (
        input  washer_found, hear_cmd, move_ready, move_done,
        output hear_en, move_valid, move_cmd, find_sound, busy, timeout
    );

    modport slave (
        output washer_found, hear_cmd, move_ready, move_done,
        input  hear_en, move_valid, move_cmd, find_sound, busy, timeout
    );
endinterface

// File: rtl/freq_cmd_sequencer.sv
// Washer-triggered sequencer: enable mic, settle, accept a stable command, issue one move.
// Define FREQ_SEQ_RETRY_EN to allow one extra settle/listen pass before reporting timeout.
module freq_cmd_sequencer #(
    parameter int SETTLE_CYCLES  = 1000,
    parameter int STABLE_CYCLES  = 5000,
    parameter int LISTEN_TIMEOUT = 100_000_000,
    parameter int TRACK_HOLD     = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    freq_cmd_sequencer_if.master bus
);

    localparam int SET_W = $clog2(SETTLE_CYCLES) + 1;
    localparam int STB_W = $clog2(STABLE_CYCLES) + 1;
    localparam int LIS_W = $clog2(LISTEN_TIMEOUT) + 1;
    localparam int TRK_W = $clog2(TRACK_HOLD) + 1;

    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [STB_W-1:0] STB_MAX  = STB_W'(STABLE_CYCLES);
    localparam logic [LIS_W-1:0] LIS_LAST = LIS_W'(LISTEN_TIMEOUT - 1);
    localparam logic [TRK_W-1:0] TRK_LAST = TRK_W'(TRACK_HOLD - 1);

    localparam logic [2:0] CMD_TURN  = 3'b001;
    localparam logic [2:0] CMD_STORE = 3'b010;
    localparam logic [2:0] CMD_SOUND = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_LISTEN,
        S_ISSUE,
        S_WAIT_DONE,
        S_TRACK
    } state_t;

    state_t           state_q, state_d;
    logic             wf_q;
    logic [2:0]       cand_q, cand_d;
    logic [STB_W-1:0] stab_q, stab_d;
    logic [SET_W-1:0] set_q, set_d;
    logic [LIS_W-1:0] lis_q, lis_d;
    logic [TRK_W-1:0] trk_q, trk_d;
    logic             hear_en_q, hear_en_d;
    logic             move_valid_q, move_valid_d;
    logic [2:0]       move_cmd_q, move_cmd_d;
    logic             find_sound_q, find_sound_d;
    logic             busy_q, busy_d;
    logic             timeout_q, timeout_d;
`ifdef FREQ_SEQ_RETRY_EN
    logic             retry_q, retry_d;
`endif

    logic wf_rise;
    logic cmd_ok;
    logic accept;
    logic lis_expire;

    function automatic logic is_valid_cmd(input logic [2:0] c);
        return (c == CMD_TURN) || (c == CMD_STORE) || (c == CMD_SOUND);
    endfunction

    assign wf_rise    = bus.washer_found & ~wf_q;
    assign cmd_ok     = is_valid_cmd(bus.hear_cmd);
    assign accept     = (stab_q == STB_MAX);
    assign lis_expire = (lis_q == LIS_LAST);

    always_ff @(posedge clk) begin
        // wf_q tracks the input even in reset so a level held across reset is not an edge
        wf_q <= bus.washer_found;
        if (rst) begin
            state_q      <= S_IDLE;
            cand_q       <= '0;
            stab_q       <= '0;
            set_q        <= '0;
            lis_q        <= '0;
            trk_q        <= '0;
            hear_en_q    <= 1'b0;
            move_valid_q <= 1'b0;
            move_cmd_q   <= '0;
            find_sound_q <= 1'b0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
`ifdef FREQ_SEQ_RETRY_EN
            retry_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cand_q       <= cand_d;
            stab_q       <= stab_d;
            set_q        <= set_d;
            lis_q        <= lis_d;
            trk_q        <= trk_d;
            hear_en_q    <= hear_en_d;
            move_valid_q <= move_valid_d;
            move_cmd_q   <= move_cmd_d;
            find_sound_q <= find_sound_d;
            busy_q       <= busy_d;
            timeout_q    <= timeout_d;
`ifdef FREQ_SEQ_RETRY_EN
            retry_q      <= retry_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        stab_d     = stab_q;
        set_d      = set_q;
        lis_d      = lis_q;
        trk_d      = trk_q;
        move_cmd_d = move_cmd_q;
        timeout_d  = 1'b0;
`ifdef FREQ_SEQ_RETRY_EN
        retry_d    = retry_q;
`endif

        case (state_q)
            S_IDLE: begin
`ifdef FREQ_SEQ_RETRY_EN
                retry_d = 1'b0;
`endif
                if (wf_rise) begin
                    state_d = S_SETTLE;
                    set_d   = '0;
                    cand_d  = '0;
                    stab_d  = '0;
                end
            end

            S_SETTLE: begin
                if (set_q == SET_LAST) begin
                    state_d = S_LISTEN;
                    lis_d   = '0;
                end else begin
                    set_d = set_q + 1'b1;
                end
            end

            S_LISTEN: begin
                if (!lis_expire) lis_d = lis_q + 1'b1;

                if (!cmd_ok) begin
                    stab_d = '0;
                end else if (bus.hear_cmd == cand_q) begin
                    stab_d = accept ? stab_q : stab_q + 1'b1;
                end else begin
                    cand_d = bus.hear_cmd;
                    stab_d = STB_W'(1);
                end

                // acceptance takes priority over a coincident timeout
                if (accept) begin
                    move_cmd_d = cand_q;
                    state_d    = S_ISSUE;
                end else if (lis_expire) begin
`ifdef FREQ_SEQ_RETRY_EN
                    if (!retry_q) begin
                        retry_d = 1'b1;
                        state_d = S_SETTLE;
                        set_d   = '0;
                        cand_d  = '0;
                        stab_d  = '0;
                    end else begin
                        timeout_d = 1'b1;
                        state_d   = S_IDLE;
                    end
`else
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
`endif
                end
            end

            S_ISSUE: begin
                if (move_valid_q && bus.move_ready) begin
                    if (move_cmd_q == CMD_SOUND) begin
                        state_d = S_TRACK;
                        trk_d   = '0;
                    end else begin
                        state_d = S_WAIT_DONE;
                    end
                end
            end

            S_WAIT_DONE: begin
                if (bus.move_done) state_d = S_IDLE;
            end

            S_TRACK: begin
                if (bus.move_done || (trk_q == TRK_LAST)) begin
                    state_d = S_IDLE;
                end else begin
                    trk_d = trk_q + 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase

        // outputs are registered copies decoded from the next state
        hear_en_d    = (state_d == S_SETTLE) || (state_d == S_LISTEN) || (state_d == S_TRACK) ||
                       ((state_d == S_ISSUE) && (move_cmd_d == CMD_SOUND));
        move_valid_d = (state_d == S_ISSUE);
        find_sound_d = (state_d == S_TRACK);
        busy_d       = (state_d != S_IDLE);
    end

    assign bus.hear_en    = hear_en_q;
    assign bus.move_valid = move_valid_q;
    assign bus.move_cmd   = move_cmd_q;
    assign bus.find_sound = find_sound_q;
    assign bus.busy       = busy_q;
    assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_freq_cmd_sequencer.sv
// Randomized bench for freq_cmd_sequencer: each sequence builds an expected output
// timeline from run-length rules over the stimulus, then drives and compares per cycle.
module tb_freq_cmd_sequencer;

    localparam int SETTLE  = 4;
    localparam int STABLE  = 3;
    localparam int TIMEOUT = 20;
    localparam int TRACK   = 10;
    localparam int N       = 320;
`ifdef FREQ_SEQ_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    freq_cmd_sequencer_if bus();

    freq_cmd_sequencer #(
        .SETTLE_CYCLES (SETTLE),
        .STABLE_CYCLES (STABLE),
        .LISTEN_TIMEOUT(TIMEOUT),
        .TRACK_HOLD    (TRACK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // stimulus per sampling edge and expected outputs after each edge
    bit       s_wf[N];
    bit       s_rdy[N];
    bit       s_done[N];
    logic [2:0] s_cmd[N];
    bit       e_hear[N];
    bit       e_busy[N];
    bit       e_valid[N];
    bit       e_find[N];
    bit       e_to[N];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] rand_valid();
        logic [2:0] one = 3'b001;
        return one << $urandom_range(0, 2);
    endfunction

    function automatic logic [2:0] rand_invalid();
        case ($urandom_range(0, 4))
            0: return 3'b000;
            1: return 3'b011;
            2: return 3'b101;
            3: return 3'b110;
            default: return 3'b111;
        endcase
    endfunction

    function automatic bit is_valid(input logic [2:0] c);
        return (c == 3'b001) || (c == 3'b010) || (c == 3'b100);
    endfunction

    // mode 0: random runs, 1: never valid, 2: one constant code, 3: 001,001,100,100,...
    task automatic gen_listen(input int mode, input int base);
        int j;
        int rl;
        logic [2:0] v;
        j = 0;
        v = rand_valid();
        while (j < TIMEOUT) begin
            case (mode)
                1: begin s_cmd[base + j] = rand_invalid(); j++; end
                2: begin s_cmd[base + j] = v; j++; end
                3: begin s_cmd[base + j] = (j < 2) ? 3'b001 : 3'b100; j++; end
                default: begin
                    if ($urandom_range(0, 3) == 0) begin
                        v  = rand_invalid();
                        rl = $urandom_range(1, 2);
                    end else begin
                        v  = rand_valid();
                        rl = $urandom_range(1, 4);
                    end
                    for (int k = 0; k < rl && j < TIMEOUT; k++) begin
                        s_cmd[base + j] = v;
                        j++;
                    end
                end
            endcase
        end
    endtask

    task automatic mark(input int lo, input int hi, input bit hear, input bit valid, input bit find);
        for (int c = lo; c <= hi; c++) begin
            e_busy[c]  = 1'b1;
            e_hear[c]  = hear;
            e_valid[c] = valid;
            e_find[c]  = find;
        end
    endtask

    task automatic run_seq(input int mode, input int rdel_in);
        int t, l, att, jacc, run, a, r, k, d, endc, last, done_hi;
        bit fin, acc, hold;
        logic [2:0] prev, v, acmd;

        for (int c = 0; c < N; c++) begin
            s_wf[c] = 1'($urandom_range(0, 1));
            s_rdy[c] = 1'($urandom_range(0, 1));
            s_done[c] = 1'b0;
            s_cmd[c] = 3'($urandom_range(0, 7));
            e_hear[c] = 1'b0; e_busy[c] = 1'b0; e_valid[c] = 1'b0;
            e_find[c] = 1'b0; e_to[c] = 1'b0;
        end
        s_wf[0] = 1'b1;
        t = 0; att = 0; fin = 1'b0; acc = 1'b0;
        a = 0; endc = 0; acmd = 3'b000;

        while (!fin) begin
            mark(t, t + SETTLE - 1, 1'b1, 1'b0, 1'b0);
            l = t + SETTLE;
            gen_listen(mode, l + 1);
            run = 0; prev = 3'b000; jacc = -1;
            for (int j = 0; j < TIMEOUT; j++) begin
                v = s_cmd[l + 1 + j];
                if (is_valid(v)) begin
                    run  = (v == prev) ? run + 1 : 1;
                    prev = v;
                end else begin
                    run = 0;
                end
                if (run >= STABLE && jacc < 0) jacc = j;
            end
            if (jacc >= 0 && jacc <= TIMEOUT - 2) begin
                a    = l + 2 + jacc;
                acmd = s_cmd[l + 1 + jacc];
                mark(l, a - 1, 1'b1, 1'b0, 1'b0);
                acc  = 1'b1;
                fin  = 1'b1;
            end else begin
                mark(l, l + TIMEOUT - 1, 1'b1, 1'b0, 1'b0);
                if (RETRY && att == 0) begin
                    att = 1;
                    t   = l + TIMEOUT;
                end else begin
                    endc       = l + TIMEOUT;
                    e_to[endc] = 1'b1;
                    fin        = 1'b1;
                end
            end
        end

        done_hi = endc;
        if (acc) begin
            r = (rdel_in < 0) ? $urandom_range(0, 7) : rdel_in;
            mark(a, a + r, acmd == 3'b100, 1'b1, 1'b0);
            for (int c = a + 1; c <= a + r; c++) s_rdy[c] = 1'b0;
            s_rdy[a + r + 1] = 1'b1;
            k = a + r + 1;
            done_hi = k;
            if (acmd == 3'b100) begin
                d    = $urandom_range(0, TRACK + 2);
                endc = (k + 1 + d < k + TRACK) ? k + 1 + d : k + TRACK;
                mark(k, endc - 1, 1'b1, 1'b0, 1'b1);
            end else begin
                d    = $urandom_range(0, 5);
                endc = k + 1 + d;
                mark(k, endc - 1, 1'b0, 1'b0, 1'b0);
            end
        end
        // stray completions before the move is accepted must be ignored
        for (int c = 1; c <= done_hi; c++) s_done[c] = ($urandom_range(0, 7) == 0);
        if (acc) s_done[k + 1 + d] = 1'b1;

        hold = ($urandom_range(0, 3) == 0);
        last = endc + 4;
        if (hold) begin
            for (int c = 0; c <= endc + 2; c++) s_wf[c] = 1'b1;
            s_wf[endc + 3] = 1'b0;
            s_wf[endc + 4] = 1'b0;
        end else begin
            for (int c = endc - 1; c <= last; c++) s_wf[c] = 1'b0;
        end

        for (int c = 0; c <= last; c++) begin
            bus.washer_found = s_wf[c];
            bus.hear_cmd     = s_cmd[c];
            bus.move_ready   = s_rdy[c];
            bus.move_done    = s_done[c];
            tick();
            chk("hear_en",    32'(bus.hear_en),    32'(e_hear[c]));
            chk("busy",       32'(bus.busy),       32'(e_busy[c]));
            chk("move_valid", 32'(bus.move_valid), 32'(e_valid[c]));
            chk("find_sound", 32'(bus.find_sound), 32'(e_find[c]));
            chk("timeout",    32'(bus.timeout),    32'(e_to[c]));
            if (e_valid[c]) chk("move_cmd", 32'(bus.move_cmd), 32'(acmd));
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_hear_en"},    32'(bus.hear_en),    32'd0);
        chk({tag, "_move_valid"}, 32'(bus.move_valid), 32'd0);
        chk({tag, "_move_cmd"},   32'(bus.move_cmd),   32'd0);
        chk({tag, "_find_sound"}, 32'(bus.find_sound), 32'd0);
        chk({tag, "_busy"},       32'(bus.busy),       32'd0);
        chk({tag, "_timeout"},    32'(bus.timeout),    32'd0);
    endtask

    // rst mid-sequence with washer_found held high; restart needs a fresh edge
    task automatic reset_mid(input int stop_c);
        bus.washer_found = 1'b1;
        bus.hear_cmd     = 3'b010;
        bus.move_ready   = 1'b0;
        bus.move_done    = 1'b0;
        for (int c = 0; c <= stop_c; c++) begin
            tick();
            if (c == SETTLE + STABLE)     chk("valid_before_8", 32'(bus.move_valid), 32'd0);
            if (c == SETTLE + STABLE + 1) begin
                chk("valid_at_8", 32'(bus.move_valid), 32'd1);
                chk("cmd_at_8",   32'(bus.move_cmd),   32'd2);
            end
        end
        chk("pre_rst_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        tick();
        chk_reset_vals("mid_rst");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("held_no_restart", 32'(bus.busy), 32'd0);
        end
        bus.washer_found = 1'b0;
        tick();
        chk("low_idle", 32'(bus.busy), 32'd0);
        bus.washer_found = 1'b1;
        tick();
        chk("restart_busy", 32'(bus.busy),    32'd1);
        chk("restart_hear", 32'(bus.hear_en), 32'd1);
        rst = 1'b1;
        bus.washer_found = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int mode;
        rst = 1'b1;
        bus.washer_found = 1'b0;
        bus.hear_cmd     = 3'b000;
        bus.move_ready   = 1'b0;
        bus.move_done    = 1'b0;
        tick();
        tick();
        chk_reset_vals("reset");
        rst = 1'b0;
        tick();

        run_seq(2, 0);
        run_seq(3, -1);
        run_seq(1, -1);
        run_seq(2, 7);
        for (int i = 0; i < 40; i++) begin
            mode = ($urandom_range(0, 5) == 0) ? 1 : ($urandom_range(0, 1) == 0 ? 0 : 2);
            run_seq(mode, -1);
        end

        reset_mid(SETTLE + 1);
        reset_mid(SETTLE + STABLE + 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
